// File: rtl/seq_square_pkg.sv
// Shared types and sizing helpers for the iterative squarer.
// Holds the FSM state enum, the default operand width and the counter width function.
package seq_square_pkg;

  localparam int unsigned SQ_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Counter width for w iterations: clog2(w), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < w) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/square_check.sv
// Combinational root check: compares a finished square against a radicand.
// Ports: acc (x*x), x, n (radicand) -> is_exact (acc==n), root_ok (acc<=n<(x+1)^2).
import seq_square_pkg::*;

module square_check #(
  parameter int unsigned W = SQ_W
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   x,
  input  logic [2*W-1:0] n,
  output logic           is_exact,
  output logic           root_ok
);

  // (x+1)^2 = x^2 + 2x + 1 can reach 2^(2W), so keep one extra bit.
  logic [2*W:0] next_sq;

  assign next_sq  = {1'b0, acc}
                  + {{W{1'b0}}, x, 1'b0}
                  + {{(2*W){1'b0}}, 1'b1};
  assign is_exact = (acc == n);
  assign root_ok  = (acc <= n) && ({1'b0, n} < next_sq);

endmodule

// File: rtl/seq_square.sv
// Iterative shift-add squarer: W-bit x in over valid/ready, 2W-bit x*x out after W cycles.
// Ports: clk, rst_n, in_valid/in_ready/x, out_valid/out_ready/sq; with SQUARE_VERIFY_EN also n, is_exact, root_ok.
import seq_square_pkg::*;

module seq_square #(
  parameter int unsigned W = SQ_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
`ifdef SQUARE_VERIFY_EN
  input  logic [2*W-1:0] n,
  output logic           is_exact,
  output logic           root_ok,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] sq
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state;
  state_t state_nxt;

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last;

  assign accept  = in_valid & in_ready;
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sq     <= '0;
    end else if (accept) begin
      mcand  <= {{W{1'b0}}, x};
      mplier <= x;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      // Capture the final sum so sq is stable through DONE.
      if (last) sq <= acc_nxt;
    end
  end

`ifdef SQUARE_VERIFY_EN
  logic [W-1:0]   x_q;
  logic [2*W-1:0] n_q;
  logic           exact_c;
  logic           ok_c;

  square_check #(.W(W)) u_check (
    .acc      (acc_nxt),
    .x        (x_q),
    .n        (n_q),
    .is_exact (exact_c),
    .root_ok  (ok_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      n_q      <= '0;
      is_exact <= 1'b0;
      root_ok  <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= x;
        n_q <= n;
      end
      if (last) begin
        is_exact <= exact_c;
        root_ok  <= ok_c;
      end
    end
  end
`endif

endmodule
